// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder: accepts one load/store at a time,
// holds it for LATENCY wait cycles, then returns read data or a store
// acknowledge (with an error flag for misaligned / out-of-range words).
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               accept, do_access;

  // Request captured at accept; data only, so it carries no reset.
  logic               lat_we;
  logic [31:0]        lat_addr, lat_wdata;

  // Access operands: taken straight from the port when LATENCY is zero
  // (access happens on the accept edge), else from the captured request.
  logic               acc_we, acc_err;
  logic [31:0]        acc_addr, acc_wdata;
  logic [IDX_W-1:0]   acc_idx;

  logic [31:0]        mem [DEPTH];

  // State register and wait counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= CNT_LOAD;
      else if (state == WAIT && cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    do_access  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            do_access = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          do_access = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Select access operands and decode alignment / range errors.
  always_comb begin
    acc_we    = (state == IDLE) ? req_we    : lat_we;
    acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
    acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    acc_idx   = acc_addr[IDX_W+1:2];
    acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr[31:IDX_W+2] != '0);
  end

  // Capture the request on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we    <= req_we;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

  // Word RAM write port; erroring stores never touch the array.
  always_ff @(posedge clk) begin
    if (do_access && acc_we && !acc_err)
      mem[acc_idx] <= acc_wdata;
  end

  // Response data/error: loaded on entry to RESP, held until handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (do_access) begin
      resp_err   <= acc_err;
      resp_rdata <= (acc_err || acc_we) ? 32'h0 : mem[acc_idx];
    end else if (state == RESP && resp_ready) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Handshaked, wait-stated data-memory responder that serves the processor's load/store port.
- Sits between the core's data interface and an internal word RAM.
- Accepts one request at a time and returns a read word or a write acknowledge after a programmable number of wait cycles.
- Supports multicycle/stall-capable core variants and slow-memory verification.

Parameters:
DEPTH, 64, number of 32-bit words in internal RAM (power of two)
LATENCY, 2, wait cycles between request accept and response (0 allowed)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  initiator presents a request
req_ready  output  1  responder can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address, word aligned
req_wdata  input  32  store data
resp_valid  output  1  response available
resp_ready  input  1  initiator consumes response
resp_rdata  output  32  load data; 0 for stores and errors
resp_err  output  1  misaligned or out-of-range access

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0. RAM contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch we/addr/wdata.
  - LATENCY>0: load counter=LATENCY-1, go WAIT.
  - LATENCY=0: perform access, go RESP.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle. At counter==0, perform access and go RESP on the next edge.
  - Total accept-to-resp_valid latency is LATENCY+1 cycles.
- Access:
  - Word index = addr[31:2].
  - Error if addr[1:0]!=0 or index>=DEPTH. On error: no RAM write, rdata=0, err=1.
  - Store: RAM[index]<=wdata on the edge entering RESP; rdata=0.
  - Load: rdata=RAM[index] sampled on the edge entering RESP.
- RESP:
  - resp_valid=1. resp_rdata and resp_err are held stable until handshake.
  - On resp_valid&&resp_ready: go IDLE, clear resp_valid/rdata/err.
  - req_ready=0 throughout RESP, so there is no same-cycle accept. The next accept is possible at earliest the cycle after the handshake.
- Requests while req_ready=0 are ignored; no queuing. The initiator must hold req_valid.
- Minimum throughput: one access per LATENCY+2 cycles.
- Load after store to the same address returns the new data.
- Reset mid-operation: a store still in WAIT is discarded (RAM unchanged). A store already committed remains.
- resp_ready held high while idle has no effect.

Test Plan:
1. Reset low 3 cycles, release; LATENCY=2 -> req_ready=1, resp_valid=0, rdata=0, err=0 after reset.
2. Store addr=84 data=72 at cycle t (accepted), resp_ready=1 -> resp_valid=1 at t+3, err=0, rdata=0; then load addr=84 -> resp_rdata=72 at accept+3.
3. Load addr=86 (misaligned), then store addr=256 (index 64 ≥ DEPTH) -> both give resp_err=1, rdata=0; a subsequent load of addr=0 returns its prior value unchanged.
4. Backpressure: resp_ready=0 for 5 cycles after resp_valid, with req_valid pulsed with a new request meanwhile -> resp_valid/rdata stable, req_ready=0, new request not accepted; accepted the cycle after the handshake.
5. Reset mid-op: store addr=80 data=0xDEAD accepted, assert reset during WAIT -> outputs return to reset values immediately; a later load addr=80 returns its pre-store value.
6. LATENCY=0 build: back-to-back store addr=4 data=7 and load addr=4 -> each resp_valid one cycle after accept; load rdata=7; one access per 2 cycles.
